// File: rtl/demux_pkg.sv
// Shared constants and types for the 1x2 demux dispatch front-end.
package demux_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/demux_out_buf.sv
// Single-entry output buffer: holds one beat and exposes EMPTY/FULL state.
module demux_out_buf
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic [DATA_W-1:0] i_data,
  output chan_state_e       o_state,
  output logic [DATA_W-1:0] o_data
);

  chan_state_e       r_state;
  chan_state_e       w_next;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // A load in the same cycle as a drain keeps the entry FULL with the new beat.
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   if (i_load) w_next = FULL;
      FULL:    if (!i_load && i_drain) w_next = EMPTY;
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_state = r_state;
  assign o_data  = r_data;

endmodule

// File: rtl/demux_dispatch_1x2.sv
// Registered 1x2 dispatch front-end: round-robin or per-beat select steering.
// Optional per-channel saturating beat counters under DEMUX_STATS_EN.
module demux_dispatch_1x2
  import demux_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int RR_MODE = 1
`ifdef DEMUX_STATS_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              cur_sel
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
`endif
);

  // Handshake: a beat transfers on any rising edge where valid and ready are
  // both high; valid never waits on ready, and a held beat keeps its data.
  logic        r_rr_ptr;
  logic        w_tgt;
  logic        w_accept;
  logic        w_load0;
  logic        w_load1;
  chan_state_e w_st0;
  chan_state_e w_st1;

  assign w_tgt    = (RR_MODE != 0) ? r_rr_ptr : in_sel;
  assign cur_sel  = w_tgt;
  // No skipping: a stalled target blocks input even if the other side is empty.
  assign in_ready = (w_tgt == CH1) ? (!out1_valid || out1_ready)
                                   : (!out0_valid || out0_ready);
  assign w_accept = in_valid && in_ready;
  assign w_load0  = w_accept && (w_tgt == CH0);
  assign w_load1  = w_accept && (w_tgt == CH1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= CH0;
    end else if (w_accept) begin
      r_rr_ptr <= ~r_rr_ptr;
    end
  end

  demux_out_buf #(.DATA_W(DATA_W)) u_buf0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load0),
    .i_drain (out0_ready),
    .i_data  (in_data),
    .o_state (w_st0),
    .o_data  (out0_data)
  );

  demux_out_buf #(.DATA_W(DATA_W)) u_buf1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load1),
    .i_drain (out1_ready),
    .i_data  (in_data),
    .o_state (w_st1),
    .o_data  (out1_data)
  );

  assign out0_valid = (w_st0 == FULL);
  assign out1_valid = (w_st1 == FULL);

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_load0 && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_load1 && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux_dispatch_1x2.sv
// Scoreboard bench for demux_dispatch_1x2: RR instance (index 0) and select instance (index 1).
module tb_demux_dispatch_1x2;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    iv, ir, isel, cs;
  logic [DW-1:0] idata [2];
  logic [3:0]    ov, ordy;
  logic [DW-1:0] od [4];

  logic [DW-1:0] exp_q [4][$];
  int            errors = 0;
  int            checks = 0;
  logic [3:0]    hold;
  logic [DW-1:0] hold_data [4];
  logic          seen_d1ch0;

`ifdef DEMUX_STATS_EN
  logic [3:0] cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  demux_dispatch_1x2 #(
    .DATA_W (DW),
    .RR_MODE(1)
`ifdef DEMUX_STATS_EN
    ,
    .CNT_W  (4)
`endif
  ) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[0]),
    .in_ready  (ir[0]),
    .in_data   (idata[0]),
    .in_sel    (isel[0]),
    .out0_valid(ov[0]),
    .out0_ready(ordy[0]),
    .out0_data (od[0]),
    .out1_valid(ov[1]),
    .out1_ready(ordy[1]),
    .out1_data (od[1]),
    .cur_sel   (cs[0])
`ifdef DEMUX_STATS_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`endif
  );

  demux_dispatch_1x2 #(
    .DATA_W (DW),
    .RR_MODE(0)
  ) dut_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[1]),
    .in_ready  (ir[1]),
    .in_data   (idata[1]),
    .in_sel    (isel[1]),
    .out0_valid(ov[2]),
    .out0_ready(ordy[2]),
    .out0_data (od[2]),
    .out1_valid(ov[3]),
    .out1_ready(ordy[3]),
    .out1_data (od[3]),
    .cur_sel   (cs[1])
`ifdef DEMUX_STATS_EN
    ,
    .cnt0      (),
    .cnt1      ()
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one beat on instance d; expected channel ch is hand-supplied.
  task automatic send(input int d, input logic [DW-1:0] data, input logic sel,
                      input int ch, output int stalls);
    int n;
    bit ok;
    n = d * 2 + ch;
    ok = 1'b0;
    stalls = 0;
    iv[d] = 1'b1;
    idata[d] = data;
    isel[d] = sel;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ir[d]) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat %0h on dut %0d never accepted", data, d);
      iv[d] = 1'b0;
      return;
    end
    exp_q[n].push_back(data);
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    chk("lat_valid", 32'(ov[n]), 32'd1);
    chk("lat_data", 32'(od[n]), 32'(data));
  endtask

  // Monitor: pops on every output handshake and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 4'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (hold[k]) chk("stable_data", 32'(od[k]), 32'(hold_data[k]));
        if (ov[k] && ordy[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: out %0d data %0h, none expected", k, od[k]);
          end else begin
            chk("out_data", 32'(od[k]), 32'(exp_q[k].pop_front()));
          end
        end
        hold[k] = ov[k] && !ordy[k];
        hold_data[k] = od[k];
      end
      if (ov[2]) seen_d1ch0 = 1'b1;
    end
  end

  initial begin
    logic [DW-1:0] t1 [4];
    int st, st2;
    t1[0] = 8'hA1; t1[1] = 8'hB2; t1[2] = 8'hC3; t1[3] = 8'hD4;
    rst_n = 1'b0;
    iv = '0; isel = '0; idata[0] = '0; idata[1] = '0;
    ordy = 4'hF;
    hold = '0;
    seen_d1ch0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_valids", 32'(ov), 32'd0);
    for (int k = 0; k < 4; k++) chk("rst_data", 32'(od[k]), 32'd0);
    chk("rst_cur_sel", 32'(cs[0]), 32'd0);
    chk("rst_in_ready", 32'(ir), 32'd3);

    // Round-robin, both readys high, back-to-back
    for (int i = 0; i < 4; i++) begin
      chk("t1_cur_sel", 32'(cs[0]), 32'(i % 2));
      send(0, t1[i], 1'b0, i % 2, st);
      chk("t1_no_stall", 32'(st), 32'd0);
    end

    // ch0 stalled: 0x33 must wait even though ch1 is empty
    ordy[0] = 1'b0;
    send(0, 8'h11, 1'b0, 0, st);
    send(0, 8'h22, 1'b0, 1, st);
    fork
      send(0, 8'h33, 1'b0, 0, st2);
      begin
        repeat (2) @(negedge clk);
        chk("t2_stall_ready", 32'(ir[0]), 32'd0);
        chk("t2_stall_cur_sel", 32'(cs[0]), 32'd0);
        chk("t2_other_empty", 32'(ov[1]), 32'd0);
        chk("t2_hold", 32'(od[0]), 32'h11);
        @(posedge clk);
        #1 ordy[0] = 1'b1;
      end
    join

    // Select mode, all to ch1 with ch1 ready toggling
    chk("t3_cur_sel0", 32'(cs[1]), 32'd0);
    fork
      begin
        send(1, 8'h05, 1'b1, 1, st);
        send(1, 8'h06, 1'b1, 1, st);
        send(1, 8'h07, 1'b1, 1, st);
      end
      begin
        repeat (8) begin
          @(posedge clk);
          #1 ordy[3] = ~ordy[3];
        end
      end
    join
    ordy[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_ch0_idle", 32'(seen_d1ch0), 32'd0);
    isel[1] = 1'b1;
    #1 chk("t3_cur_sel1", 32'(cs[1]), 32'd1);
    send(1, 8'h08, 1'b0, 0, st);

    // Async reset with both RR channels full
    repeat (2) @(posedge clk);
    #1 ordy = 4'b0000;
    send(0, 8'h44, 1'b0, 1, st);
    send(0, 8'h55, 1'b0, 0, st);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid0", 32'(ov[0]), 32'd0);
    chk("arst_valid1", 32'(ov[1]), 32'd0);
    chk("arst_data0", 32'(od[0]), 32'd0);
    chk("arst_data1", 32'(od[1]), 32'd0);
    chk("arst_cur_sel", 32'(cs[0]), 32'd0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    ordy = 4'hF;
    #1 chk("post_rst_cur_sel", 32'(cs[0]), 32'd0);
    send(0, 8'h66, 1'b0, 0, st);
`ifdef DEMUX_STATS_EN
    chk("cnt0_one", 32'(cnt0), 32'd1);
    chk("cnt1_zero", 32'(cnt1), 32'd0);
`endif

    // 40 RR beats; pointer is at ch1 after 0x66
    for (int i = 0; i < 40; i++) send(0, 8'(8'h80 + i), 1'b0, (i + 1) % 2, st);
`ifdef DEMUX_STATS_EN
    chk("cnt0_sat", 32'(cnt0), 32'd15);
    chk("cnt1_sat", 32'(cnt1), 32'd15);
`endif

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk("queue_drained", 32'(exp_q[k].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
